// File: rtl/ddr3_ui_pkg.sv
// Shared definitions for the two-port DDR3 UI arbiter: command encodings,
// arbiter states and default widths.
package ddr3_ui_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 288;
    localparam int MASK_W_DEF    = 36;
    localparam int TAG_DEPTH_DEF = 32;
    localparam int MAX_GRANT_DEF = 16;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    function automatic state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/ddr3_ui_tag_fifo.sv
// In-order FIFO of one-bit port tags, one entry per read in flight.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ddr3_ui_tag_fifo
    import ddr3_ui_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PTR_W-1:0]] <= din;
    end

    assign dout  = mem[rptr[PTR_W-1:0]];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

endmodule

// File: rtl/ddr3_ui_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller UI between two requesters;
// read beats are routed back to their issuing port through an in-order tag FIFO.
module ddr3_ui_arbiter
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MASK_W    = MASK_W_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF,
    parameter int MAX_GRANT = MAX_GRANT_DEF
) (
    input  logic                        ddr3_app_clk,
    input  logic                        ddr3_rst,
    input  logic                        p0_req_valid,
    output logic                        p0_req_rdy,
    input  logic                        p0_req_cmd,
    input  logic [ADDR_W-1:0]           p0_req_addr,
    input  logic [DATA_W-1:0]           p0_req_data,
    input  logic [MASK_W-1:0]           p0_req_mask,
    output logic [DATA_W-1:0]           p0_rd_data,
    output logic                        p0_rd_valid,
    input  logic                        p1_req_valid,
    output logic                        p1_req_rdy,
    input  logic                        p1_req_cmd,
    input  logic [ADDR_W-1:0]           p1_req_addr,
    input  logic [DATA_W-1:0]           p1_req_data,
    input  logic [MASK_W-1:0]           p1_req_mask,
    output logic [DATA_W-1:0]           p1_rd_data,
    output logic                        p1_rd_valid,
    input  logic                        phy_rdy,
    input  logic                        app_rdy,
    input  logic                        app_wdf_rdy,
    output logic                        app_en,
    output logic [2:0]                  app_cmd,
    output logic [ADDR_W-1:0]           app_addr,
    output logic [DATA_W-1:0]           app_wdf_data,
    output logic [MASK_W-1:0]           app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic [DATA_W-1:0]           app_rd_data,
    input  logic                        app_rd_data_valid,
    output logic                        err_orphan_rd,
    output logic [$clog2(TAG_DEPTH):0]  rd_outstanding
);

    localparam int GCNT_W = $clog2(MAX_GRANT + 1);

    state_t              state;
    logic                last_owner;
    logic [GCNT_W-1:0]   gcnt;

    logic                owned, owner;
    logic                own_valid, other_valid, own_cmd;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_data;
    logic [MASK_W-1:0]   own_mask;
    logic                idle_pick, grant_spent, can_issue;
    logic                tag_push, tag_pop, tag_dout, tag_full, tag_empty;

    assign owned       = (state != IDLE);
    assign owner       = (state == OWN1);
    assign own_valid   = owned & (owner ? p1_req_valid : p0_req_valid);
    assign other_valid = owner ? p0_req_valid : p1_req_valid;
    assign own_cmd     = owner ? p1_req_cmd  : p0_req_cmd;
    assign own_addr    = owner ? p1_req_addr : p0_req_addr;
    assign own_data    = owner ? p1_req_data : p0_req_data;
    assign own_mask    = owner ? p1_req_mask : p0_req_mask;
    assign idle_pick   = (p0_req_valid & p1_req_valid) ? ~last_owner : p1_req_valid;

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign tag_pop   = app_rd_data_valid & ~tag_empty;
    assign can_issue = own_valid & phy_rdy & app_rdy &
                       (own_cmd ? (~tag_full | tag_pop) : app_wdf_rdy);
    assign tag_push  = can_issue & own_cmd;

    // Counting the command accepted this cycle hands over right after the last one.
    assign grant_spent = ({1'b0, gcnt} + {{GCNT_W{1'b0}}, can_issue}) >= (GCNT_W+1)'(MAX_GRANT);

    assign p0_req_rdy   = can_issue & ~owner;
    assign p1_req_rdy   = can_issue & owner;
    assign app_en       = can_issue;
    assign app_cmd      = (owned & own_cmd) ? CMD_RD : CMD_WR;
    assign app_addr     = owned ? own_addr : '0;
    assign app_wdf_data = owned ? own_data : '0;
    assign app_wdf_mask = owned ? own_mask : '0;
    assign app_wdf_wren = can_issue & ~own_cmd;
    assign app_wdf_end  = can_issue & ~own_cmd;

    always_ff @(posedge ddr3_app_clk or posedge ddr3_rst) begin
        if (ddr3_rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            gcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req_valid | p1_req_valid) begin
                        state      <= own_state(idle_pick);
                        last_owner <= idle_pick;
                        gcnt       <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_valid || (grant_spent && other_valid)) begin
                        gcnt <= '0;
                        if (other_valid) begin
                            state      <= own_state(~owner);
                            last_owner <= ~owner;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (can_issue && gcnt != GCNT_W'(MAX_GRANT)) begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ddr3_app_clk or posedge ddr3_rst) begin
        if (ddr3_rst) begin
            p0_rd_valid   <= 1'b0;
            p1_rd_valid   <= 1'b0;
            p0_rd_data    <= '0;
            p1_rd_data    <= '0;
            err_orphan_rd <= 1'b0;
        end else begin
            p0_rd_valid <= tag_pop & ~tag_dout;
            p1_rd_valid <= tag_pop & tag_dout;
            if (tag_pop & ~tag_dout) p0_rd_data <= app_rd_data;
            if (tag_pop & tag_dout)  p1_rd_data <= app_rd_data;
            if (app_rd_data_valid & tag_empty) err_orphan_rd <= 1'b1;
        end
    end

    ddr3_ui_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (ddr3_app_clk),
        .rst   (ddr3_rst),
        .push  (tag_push),
        .din   (owner),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (rd_outstanding)
    );

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Self-checking bench for ddr3_ui_arbiter with MAX_GRANT=4 and TAG_DEPTH=4;
// read returns are checked by a scoreboard fed from the bench's own tag model.
module tb_ddr3_ui_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 288;
    localparam int MASK_W    = 36;
    localparam int TAG_DEPTH = 4;
    localparam int MAX_GRANT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p0_req_valid = 0, p0_req_rdy, p0_req_cmd = 0;
    logic [ADDR_W-1:0] p0_req_addr = '0;
    logic [DATA_W-1:0] p0_req_data = '0;
    logic [MASK_W-1:0] p0_req_mask = '0;
    logic [DATA_W-1:0] p0_rd_data;
    logic p0_rd_valid;
    logic p1_req_valid = 0, p1_req_rdy, p1_req_cmd = 0;
    logic [ADDR_W-1:0] p1_req_addr = '0;
    logic [DATA_W-1:0] p1_req_data = '0;
    logic [MASK_W-1:0] p1_req_mask = '0;
    logic [DATA_W-1:0] p1_rd_data;
    logic p1_rd_valid;
    logic phy_rdy = 0, app_rdy = 0, app_wdf_rdy = 0;
    logic app_en, app_wdf_wren, app_wdf_end;
    logic [2:0] app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic app_rd_data_valid = 0;
    logic err_orphan_rd;
    logic [$clog2(TAG_DEPTH):0] rd_outstanding;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_exp_t;

    logic    tag_q[$];
    rd_exp_t exp_q[$];
    rd_exp_t e;

    typedef struct packed {
        logic cmd, phy, ardy, wrdy;
        logic exp_rdy, exp_en, exp_wren;
    } vec_t;
    vec_t vecs[8];

    ddr3_ui_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .TAG_DEPTH(TAG_DEPTH), .MAX_GRANT(MAX_GRANT)
    ) dut (
        .ddr3_app_clk(clk), .ddr3_rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_rdy(p0_req_rdy), .p0_req_cmd(p0_req_cmd),
        .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data), .p0_req_mask(p0_req_mask),
        .p0_rd_data(p0_rd_data), .p0_rd_valid(p0_rd_valid),
        .p1_req_valid(p1_req_valid), .p1_req_rdy(p1_req_rdy), .p1_req_cmd(p1_req_cmd),
        .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data), .p1_req_mask(p1_req_mask),
        .p1_rd_data(p1_rd_data), .p1_rd_valid(p1_rd_valid),
        .phy_rdy(phy_rdy), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .err_orphan_rd(err_orphan_rd), .rd_outstanding(rd_outstanding)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] s);
        return {9{s}};
    endfunction

    function automatic logic [MASK_W-1:0] mk_mask(input logic [31:0] s);
        return {4'hA, s};
    endfunction

    task automatic drive_port(input logic port, input logic valid, input logic cmd, input logic [31:0] addr);
        if (port) begin
            p1_req_valid = valid; p1_req_cmd = cmd; p1_req_addr = addr;
            p1_req_data = mk_data(addr); p1_req_mask = mk_mask(addr);
        end else begin
            p0_req_valid = valid; p0_req_cmd = cmd; p0_req_addr = addr;
            p0_req_data = mk_data(addr); p0_req_mask = mk_mask(addr);
        end
    endtask

    task automatic idle(input int n);
        p0_req_valid = 0;
        p1_req_valid = 0;
        app_rd_data_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one returned beat and book where it must appear one cycle later.
    task automatic beat_set(input logic [DATA_W-1:0] d);
        logic p;
        app_rd_data_valid = 1'b1;
        app_rd_data = d;
        if (tag_q.size() > 0) begin
            p = tag_q.pop_front();
            exp_q.push_back('{p, d, cyc + 1});
        end
    endtask

    task automatic issue_one(input logic port, input logic cmd, input logic [31:0] addr);
        logic done;
        done = 1'b0;
        drive_port(port, 1'b1, cmd, addr);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((port ? p1_req_rdy : p0_req_rdy) === 1'b1) begin
                done = 1'b1;
                check("issue_en", app_en, 1'b1);
                check("issue_cmd", app_cmd, cmd ? 3'b001 : 3'b000);
                check("issue_addr", app_addr, addr);
                if (cmd) tag_q.push_back(port);
            end
            @(posedge clk); #1;
        end
        if (!done) check("issue_timeout_rdy", port ? p1_req_rdy : p0_req_rdy, 1'b1);
        drive_port(port, 1'b0, cmd, addr);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("rd_valid_route", {p1_rd_valid, p0_rd_valid}, e.port ? 2'b10 : 2'b01);
                check("rd_data", e.port ? p1_rd_data : p0_rd_data, e.data);
            end else begin
                check("rd_valid_idle", {p1_rd_valid, p0_rd_valid}, 2'b00);
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_app_en", app_en, 1'b0);
        check("rst_wren", {app_wdf_wren, app_wdf_end}, 2'b00);
        check("rst_rdy", {p1_req_rdy, p0_req_rdy}, 2'b00);
        check("rst_rd_valid", {p1_rd_valid, p0_rd_valid}, 2'b00);
        check("rst_err", err_orphan_rd, 1'b0);
        check("rst_outstanding", rd_outstanding, 0);
        check("rst_addr", app_addr, 0);
        @(posedge clk); #1;
        rst = 0;
        phy_rdy = 1; app_rdy = 1; app_wdf_rdy = 1;

        // Four back-to-back writes from p0
        drive_port(0, 1, 0, 32'h10);
        @(negedge clk);
        check("w4_idle_en", app_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_port(0, 1, 0, 32'h10 + i);
            @(negedge clk);
            check("w4_en", {app_en, app_wdf_wren, app_wdf_end, p0_req_rdy}, 4'hF);
            check("w4_cmd", app_cmd, 3'b000);
            check("w4_addr", app_addr, 32'h10 + i);
            check("w4_data", app_wdf_data, mk_data(32'h10 + i));
            check("w4_mask", app_wdf_mask, mk_mask(32'h10 + i));
        end
        @(posedge clk); #1;
        p0_req_valid = 0;
        @(negedge clk);
        check("w4_done_en", app_en, 1'b0);
        idle(2);

        // Issue-condition table for p0
        for (int i = 0; i < 8; i++) begin
            drive_port(0, 1, vecs[i].cmd, 32'h100 + i);
            phy_rdy = vecs[i].phy; app_rdy = vecs[i].ardy; app_wdf_rdy = vecs[i].wrdy;
            @(negedge clk);
            check($sformatf("vec%0d_rdy", i), {p1_req_rdy, p0_req_rdy}, {1'b0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_en", i), app_en, vecs[i].exp_en);
            check($sformatf("vec%0d_wren", i), {app_wdf_wren, app_wdf_end}, {2{vecs[i].exp_wren}});
            if (vecs[i].exp_en) begin
                check($sformatf("vec%0d_cmd", i), app_cmd, {2'b00, vecs[i].cmd});
                check($sformatf("vec%0d_addr", i), app_addr, 32'h100 + i);
                if (vecs[i].cmd) tag_q.push_back(1'b0);
            end
            @(posedge clk); #1;
        end
        phy_rdy = 1; app_rdy = 1; app_wdf_rdy = 1;
        idle(2);
        @(negedge clk);
        check("vec_outstanding", rd_outstanding, 1);
        @(posedge clk); #1;
        beat_set(mk_data(32'hBEEF_0001));
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        @(negedge clk);
        check("vec_drained", rd_outstanding, 0);
        idle(2);

        // Both ports busy: grants alternate in blocks of MAX_GRANT, p1 first
        drive_port(0, 1, 0, 32'h2000_0000);
        drive_port(1, 1, 0, 32'h3000_0000);
        @(negedge clk);
        check("rr_idle_en", app_en, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rr%0d_en", k), app_en, 1'b1);
            check($sformatf("rr%0d_rdy", k), {p1_req_rdy, p0_req_rdy}, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("rr%0d_addr", k), app_addr, ((k / 4) % 2 == 0) ? 32'h3000_0000 : 32'h2000_0000);
        end
        #1;
        idle(2);

        // Write held off by app_wdf_rdy for three cycles
        app_wdf_rdy = 0;
        drive_port(0, 1, 0, 32'h40);
        @(negedge clk);
        check("wst_idle_en", app_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("wst_stall", {app_en, p0_req_rdy, app_wdf_wren}, 3'b000);
        end
        @(posedge clk); #1;
        app_wdf_rdy = 1;
        @(negedge clk);
        check("wst_issue", {app_en, p0_req_rdy, app_wdf_wren, app_wdf_end}, 4'hF);
        @(posedge clk); #1;
        p0_req_valid = 0;
        @(negedge clk);
        check("wst_once", app_en, 1'b0);
        idle(2);

        // Reads from both ports, beats routed in issue order
        issue_one(0, 1, 32'hA);
        issue_one(1, 1, 32'hB);
        issue_one(0, 1, 32'hC);
        @(negedge clk);
        check("rd3_outstanding", rd_outstanding, 3);
        @(posedge clk); #1;
        beat_set(mk_data(32'hD0D0_0000));
        @(posedge clk); #1;
        beat_set(mk_data(32'hD1D1_0001));
        @(posedge clk); #1;
        beat_set(mk_data(32'hD2D2_0002));
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        idle(2);
        @(negedge clk);
        check("rd3_drained", rd_outstanding, 0);
        #1;
        idle(2);

        // Tag FIFO full: reads stall, writes proceed, pop and push together
        for (int i = 0; i < 4; i++) issue_one(0, 1, 32'h80 + i);
        @(negedge clk);
        check("full_outstanding", rd_outstanding, 4);
        #1;
        idle(2);
        drive_port(0, 1, 1, 32'h85);
        drive_port(1, 1, 0, 32'h90);
        @(negedge clk);
        check("full_idle_en", app_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_wr_issue", {app_en, p1_req_rdy, app_wdf_wren}, 3'b111);
        check("full_wr_cmd", app_cmd, 3'b000);
        check("full_wr_outstanding", rd_outstanding, 4);
        @(posedge clk); #1;
        p1_req_valid = 0;
        @(negedge clk);
        check("full_handover_en", app_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_rd_stall", {app_en, p0_req_rdy}, 2'b00);
        @(posedge clk); #1;
        beat_set(mk_data(32'hF0F0_0000));
        @(negedge clk);
        check("full_rd_issue", {app_en, p0_req_rdy}, 2'b11);
        check("full_rd_cmd", app_cmd, 3'b001);
        check("full_pop_push_cnt0", rd_outstanding, 4);
        tag_q.push_back(1'b0);
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        p0_req_valid = 0;
        @(negedge clk);
        check("full_pop_push_cnt1", rd_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            beat_set(mk_data(32'hF1F1_0000 + i));
        end
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        @(negedge clk);
        check("full_drained", rd_outstanding, 0);
        #1;
        idle(2);

        // Orphan beat with nothing outstanding
        @(negedge clk);
        check("orph_err_before", err_orphan_rd, 1'b0);
        @(posedge clk); #1;
        beat_set(mk_data(32'h0BAD_0000));
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        @(negedge clk);
        check("orph_err_set", err_orphan_rd, 1'b1);
        check("orph_outstanding", rd_outstanding, 0);
        #1;
        idle(3);
        @(negedge clk);
        check("orph_err_sticky", err_orphan_rd, 1'b1);
        #1;
        idle(1);

        // Reset in the middle of a write burst with a read outstanding
        issue_one(0, 1, 32'h5000);
        drive_port(0, 1, 0, 32'h6000);
        @(negedge clk);
        check("rstm_burst_en", app_en, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstm_burst_en2", app_en, 1'b1);
        #1;
        rst = 1;
        #1;
        check("rstm_en", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
        check("rstm_rdy", {p1_req_rdy, p0_req_rdy}, 2'b00);
        check("rstm_addr", app_addr, 0);
        check("rstm_wdata", app_wdf_data, 0);
        check("rstm_err", err_orphan_rd, 1'b0);
        check("rstm_outstanding", rd_outstanding, 0);
        check("rstm_rd_data", p0_rd_data, 0);
        @(posedge clk); #1;
        p0_req_valid = 0;
        tag_q.delete();
        rst = 0;
        beat_set(mk_data(32'h7777_0000));
        @(posedge clk); #1;
        app_rd_data_valid = 0;
        @(negedge clk);
        check("rstm_orphan_err", err_orphan_rd, 1'b1);
        check("rstm_orphan_cnt", rd_outstanding, 0);
        #1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
